// File: rtl/regbank_rd_stream.sv
// Streams consecutive register-bank words over valid/ready, starting at a commanded
// address for a commanded beat count. Optional rd_par output enabled by RD_PARITY_EN.
module regbank_rd_stream #(
  parameter int NUM_REGS = 16,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_REGS*DATA_W-1:0]   regs_flat,
  input  logic                         rd_req,
  input  logic [ADDR_W-1:0]            rd_addr,
  input  logic [ADDR_W-1:0]            rd_len,
  output logic                         rd_busy,
  output logic [DATA_W-1:0]            rd_data,
  output logic                         rd_valid,
  input  logic                         rd_ready,
  output logic                         rd_last,
  output logic                         rd_err
`ifdef RD_PARITY_EN
  ,
  output logic                         rd_par
`endif
);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                valid_q, valid_d;
  logic                last_q, last_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                par_q, par_d;

  logic [DATA_W-1:0]   regs_arr [NUM_REGS];
  logic [ADDR_W-1:0]   sel_addr;
  logic [ADDR_W-1:0]   sel_next;
  logic [DATA_W-1:0]   sel_data;
  logic                sel_err;

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_unpack
      assign regs_arr[gi] = regs_flat[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // One lookup serves both the first beat (from the command) and later beats.
  always_comb begin
    sel_addr = (state_q == IDLE) ? rd_addr : addr_q;
    sel_data = '0;
    sel_err  = 1'b1;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (sel_addr == ADDR_W'(i)) begin
        sel_data = regs_arr[i];
        sel_err  = 1'b0;
      end
    end
    // Wrap modulo NUM_REGS; an out-of-range start also restarts at register 0.
    sel_next = (int'(sel_addr) >= NUM_REGS - 1) ? '0 : sel_addr + ADDR_W'(1);
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    last_d  = last_q;
    err_d   = err_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (rd_req) begin
          state_d = STREAM;
          busy_d  = 1'b1;
          valid_d = 1'b1;
          data_d  = sel_data;
          err_d   = sel_err;
          last_d  = (rd_len == '0);
          cnt_d   = rd_len;
          addr_d  = sel_next;
        end
      end
      STREAM: begin
        if (valid_q && rd_ready) begin
          if (last_q) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            valid_d = 1'b0;
            last_d  = 1'b0;
            err_d   = 1'b0;
            data_d  = '0;
            cnt_d   = '0;
            addr_d  = '0;
          end else begin
            data_d  = sel_data;
            err_d   = sel_err;
            last_d  = (cnt_q == ADDR_W'(1));
            cnt_d   = cnt_q - ADDR_W'(1);
            addr_d  = sel_next;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    par_d = valid_d ? ^data_d : 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      err_q   <= err_d;
      data_q  <= data_d;
      par_q   <= par_d;
    end
  end

  assign rd_busy  = busy_q;
  assign rd_valid = valid_q;
  assign rd_last  = last_q;
  assign rd_err   = err_q;
  assign rd_data  = data_q;

`ifdef RD_PARITY_EN
  assign rd_par = par_q;
`else
  logic unused_par;
  assign unused_par = par_q;
`endif

endmodule

// File: tb/tb_regbank_rd_stream.sv
// Scoreboard bench for regbank_rd_stream (12-register bank so out-of-range starts occur).
module tb_regbank_rd_stream;
  localparam int N  = 12;
  localparam int DW = 32;
  localparam int AW = 4;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic          err;
  } beat_t;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N*DW-1:0] regs_flat;
  logic            rd_req;
  logic [AW-1:0]   rd_addr;
  logic [AW-1:0]   rd_len;
  logic            rd_busy;
  logic [DW-1:0]   rd_data;
  logic            rd_valid;
  logic            rd_ready;
  logic            rd_last;
  logic            rd_err;
`ifdef RD_PARITY_EN
  logic            rd_par;
`endif

  logic [DW-1:0] regs [N];
  beat_t         exp_q [$];
  int            tests = 0;
  int            fails = 0;

  regbank_rd_stream #(.NUM_REGS(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .regs_flat(regs_flat),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .rd_len   (rd_len),
    .rd_busy  (rd_busy),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_last  (rd_last),
    .rd_err   (rd_err)
`ifdef RD_PARITY_EN
    ,
    .rd_par   (rd_par)
`endif
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) regs_flat[i*DW +: DW] = regs[i];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: beat k of a burst reads (start+k) mod N; an out-of-range start
  // yields one error beat and then continues from register 0.
  task automatic push_cmd(input int a, input int l);
    for (int k = 0; k <= l; k++) begin
      int    ea;
      beat_t b;
      if (a < N) ea = (a + k) % N;
      else       ea = (k == 0) ? a : (k - 1) % N;
      b.data = (ea < N) ? regs[ea] : '0;
      b.err  = (ea >= N);
      b.last = (k == l);
      exp_q.push_back(b);
    end
  endtask

  // Called at #1 after a rising edge; returns #1 after the accepting edge.
  task automatic issue(input int a, input int l);
    int guard = 0;
    while (rd_busy && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 200) check("issue_wait_timeout", 64'(guard), 64'(0));
    push_cmd(a, l);
    $display("[TB] cmd addr=%0d len=%0d", a, l);
    rd_req  = 1'b1;
    rd_addr = AW'(a);
    rd_len  = AW'(l);
    @(posedge clk); #1;
    rd_req  = 1'b0;
  endtask

  task automatic drain(input int pct);
    int n = 0;
    while ((exp_q.size() != 0 || rd_valid) && n < 400) begin
      rd_ready = ($urandom_range(0, 99) < pct);
      @(posedge clk); #1;
      n++;
    end
    if (n >= 400) check("drain_timeout", 64'(exp_q.size()), 64'(0));
  endtask

  // Monitor: compare every presented beat (repeatedly while stalled), pop on handshake.
  always @(negedge clk) begin
    if (reset_n) begin
      check("busy_matches_valid", 64'(rd_busy), 64'(rd_valid));
      if (rd_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_beat", 64'(rd_valid), 64'(0));
        end else begin
          beat_t e;
          e = exp_q[0];
          check("beat_data", 64'(rd_data), 64'(e.data));
          check("beat_last", 64'(rd_last), 64'(e.last));
          check("beat_err",  64'(rd_err),  64'(e.err));
`ifdef RD_PARITY_EN
          check("beat_par",  64'(rd_par),  64'(^e.data));
`endif
          if (rd_ready) begin
            $display("[TB] beat data=0x%08h last=%0b err=%0b", rd_data, rd_last, rd_err);
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, 64'(rd_valid), 64'(0));
    check({tag, "_busy"},  64'(rd_busy),  64'(0));
    check({tag, "_last"},  64'(rd_last),  64'(0));
    check({tag, "_err"},   64'(rd_err),   64'(0));
    check({tag, "_data"},  64'(rd_data),  64'(0));
`ifdef RD_PARITY_EN
    check({tag, "_par"},   64'(rd_par),   64'(0));
`endif
  endtask

  initial begin
    int pat [5] = '{1, 0, 0, 1, 1};
    reset_n  = 1'b0;
    rd_req   = 1'b0;
    rd_addr  = '0;
    rd_len   = '0;
    rd_ready = 1'b0;
    for (int i = 0; i < N; i++) regs[i] = 32'h1000 + i;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Single read with latency and busy-release checks
    regs[5]  = 32'hDEADBEEF;
    rd_ready = 1'b1;
    issue(5, 0);
    check("single_valid", 64'(rd_valid), 64'(1));
    check("single_data",  64'(rd_data),  64'(32'hDEADBEEF));
    check("single_last",  64'(rd_last),  64'(1));
    @(posedge clk); #1;
    check("single_busy_after", 64'(rd_busy),  64'(0));
    check("single_valid_after", 64'(rd_valid), 64'(0));
    regs[5] = 32'h1005;

    // Wrap across the top of the bank
    rd_ready = 1'b1;
    issue(10, 3);
    drain(100);

    // Backpressure pattern
    issue(0, 2);
    foreach (pat[i]) begin
      rd_ready = pat[i][0];
      @(posedge clk); #1;
    end
    drain(100);

    // Out-of-range start, plus an ignored command while busy
    rd_ready = 1'b0;
    issue(13, 1);
    rd_req  = 1'b1;
    rd_addr = AW'(2);
    rd_len  = AW'(5);
    @(posedge clk); #1;
    rd_req  = 1'b0;
    drain(100);

    // A presented beat must not follow later bank writes
    rd_ready = 1'b0;
    issue(3, 1);
    regs[3] = 32'hCAFE0003;
    @(posedge clk); #1;
    @(posedge clk); #1;
    drain(100);
    regs[3] = 32'h1003;

    // Parity examples
    regs[0] = 32'h7;
    regs[1] = 32'h3;
    issue(0, 1);
    drain(100);

    // Reset mid-burst
    rd_ready = 1'b1;
    issue(0, 7);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check_idle_outputs("midreset");
    exp_q.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_idle_outputs("heldreset");
    reset_n = 1'b1;
    @(posedge clk); #1;
    issue(6, 2);
    drain(100);

    // Randomized bursts with random backpressure and stray requests while busy
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++) regs[i] = $urandom;
      rd_ready = ($urandom_range(0, 1) == 1);
      issue($urandom_range(0, 15), $urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) begin
        rd_req  = 1'b1;
        rd_addr = AW'($urandom_range(0, 15));
        rd_len  = AW'($urandom_range(0, 15));
        @(posedge clk); #1;
        rd_req  = 1'b0;
      end
      drain($urandom_range(30, 100));
    end

    rd_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("final_queue_empty", 64'(exp_q.size()), 64'(0));
    check_idle_outputs("final");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
